// File: rtl/jtag_chain_regfile.sv
// jtag_chain_regfile: addressed register file behind a JTAG user data chain.
// A frame {DATA, ADDR, WR} (LSB first) is shifted in. On update it either
// writes one of NUM_RW control registers or just points readback at an
// address. Capture loads {rd_data, rd_ptr, err} into the chain.
// Ports:
//   JTCK       - JTAG test clock, all logic on rising edge
//   JRST       - synchronous active-high reset
//   JTDI/JTDO  - serial in / registered serial out
//   JSHIFT     - shift-DR state; JCE=1 with JSHIFT=0 means capture
//   JUPDATE    - update-DR state
//   JCE        - this chain selected
//   STATUS_IN  - NUM_RO read-only status words, word k at address NUM_RW+k
//   REG_OUT    - NUM_RW control registers, register i at [i*DATA_W +: DATA_W]
//   REG_WSTB   - one-cycle write strobe per control register
module jtag_chain_regfile #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 3,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 2
) (
  input  logic                     JTCK,
  input  logic                     JRST,
  input  logic                     JTDI,
  input  logic                     JSHIFT,
  input  logic                     JUPDATE,
  input  logic                     JCE,
  output logic                     JTDO,
  input  logic [NUM_RO*DATA_W-1:0] STATUS_IN,
  output logic [NUM_RW*DATA_W-1:0] REG_OUT,
  output logic [NUM_RW-1:0]        REG_WSTB
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;

  if (NUM_RW + NUM_RO > (1 << ADDR_W)) begin : g_bad_cfg
    $error("jtag_chain_regfile: NUM_RW+NUM_RO exceeds the address space");
  end

  // Bit 0 of the chain is WR, so the struct lists fields MSB first.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wr;
  } frame_t;

  frame_t                         sr;
  logic [ADDR_W-1:0]              rd_ptr;
  logic                           err;
  logic                           sel;     // a shift happened since the last update
  logic [NUM_RW-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-1:0]              rd_data;
  logic                           upd;
  logic                           addr_ok;
  logic [NUM_RW-1:0]              wr_hit;

  assign upd     = JUPDATE & sel;
  assign addr_ok = (int'(sr.addr) < NUM_RW);
  assign REG_OUT = regs;

  for (genvar i = 0; i < NUM_RW; i++) begin : g_hit
    assign wr_hit[i] = upd & sr.wr & (sr.addr == ADDR_W'(i));
  end

  // Readback mux: control regs, then status words, anything beyond reads 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (int'(rd_ptr) == i) rd_data = regs[i];
    for (int k = 0; k < NUM_RO; k++)
      if (int'(rd_ptr) == NUM_RW + k) rd_data = STATUS_IN[k*DATA_W +: DATA_W];
  end

  always_ff @(posedge JTCK) begin
    if (JRST) begin
      sr       <= '0;
      JTDO     <= 1'b0;
      rd_ptr   <= '0;
      err      <= 1'b0;
      sel      <= 1'b0;
      regs     <= '0;
      REG_WSTB <= '0;
    end else begin
      REG_WSTB <= wr_hit;
      for (int i = 0; i < NUM_RW; i++)
        if (wr_hit[i]) regs[i] <= sr.data;
      // Update decodes the pre-edge frame; a shift at the same edge still
      // moves the chain and re-arms sel (later assignment wins).
      if (upd) begin
        rd_ptr <= sr.addr;
        err    <= sr.wr & ~addr_ok;
        sel    <= 1'b0;
      end
      if (JCE) begin
        if (JSHIFT) begin
          JTDO <= sr.wr;
          sr   <= {JTDI, sr[FRAME_W-1:1]};
          sel  <= 1'b1;
        end else begin
          sr <= '{data: rd_data, addr: rd_ptr, wr: err};
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_chain_regfile.sv
module tb_jtag_chain_regfile;
  localparam int DW  = 9;
  localparam int AW  = 3;
  localparam int NRW = 4;
  localparam int NRO = 2;
  localparam int FW  = 1 + AW + DW;

  logic              JTCK = 1'b0;
  logic              JRST = 1'b1;
  logic              JTDI = 1'b0;
  logic              JSHIFT = 1'b0;
  logic              JUPDATE = 1'b0;
  logic              JCE = 1'b0;
  logic              JTDO;
  logic [NRO*DW-1:0] STATUS_IN = '0;
  logic [NRW*DW-1:0] REG_OUT;
  logic [NRW-1:0]    REG_WSTB;

  jtag_chain_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
    .JTCK(JTCK), .JRST(JRST), .JTDI(JTDI), .JSHIFT(JSHIFT), .JUPDATE(JUPDATE),
    .JCE(JCE), .JTDO(JTDO), .STATUS_IN(STATUS_IN), .REG_OUT(REG_OUT),
    .REG_WSTB(REG_WSTB)
  );

  always #5 JTCK = ~JTCK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: chain contents as an integer frame value, registers
  // as an int array, decoded with plain arithmetic.
  int m_frame, m_tdo, m_rdp, m_err, m_sel, m_wstb;
  int m_regs [NRW];

  function automatic logic [NRW*DW-1:0] exp_reg();
    logic [NRW*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NRW; i++) r[i*DW +: DW] = m_regs[i][DW-1:0];
    return r;
  endfunction

  task automatic tick(input bit rst, input bit ce, input bit sh, input bit up, input bit tdi);
    int rd, cap, wr, addr, data;
    @(negedge JTCK);
    JRST = rst; JCE = ce; JSHIFT = sh; JUPDATE = up; JTDI = tdi;
    @(posedge JTCK);
    if (rst) begin
      m_frame = 0; m_tdo = 0; m_rdp = 0; m_err = 0; m_sel = 0; m_wstb = 0;
      for (int i = 0; i < NRW; i++) m_regs[i] = 0;
    end else begin
      if (m_rdp < NRW) rd = m_regs[m_rdp];
      else if (m_rdp < NRW + NRO) rd = int'(STATUS_IN[(m_rdp-NRW)*DW +: DW]);
      else rd = 0;
      cap  = (rd << (AW+1)) | (m_rdp << 1) | m_err;
      wr   = m_frame & 1;
      addr = (m_frame >> 1) & ((1 << AW) - 1);
      data = (m_frame >> (AW+1)) & ((1 << DW) - 1);
      m_wstb = 0;
      if (up && m_sel != 0) begin
        m_rdp = addr;
        m_sel = 0;
        if (wr == 1) begin
          if (addr < NRW) begin m_regs[addr] = data; m_wstb = 1 << addr; m_err = 0; end
          else m_err = 1;
        end else m_err = 0;
      end
      if (ce) begin
        if (sh) begin
          m_tdo   = m_frame & 1;
          m_frame = (m_frame >> 1) | (int'(tdi) << (FW-1));
          m_sel   = 1;
        end else m_frame = cap;
      end
    end
    #1;
  endtask

  // Shift n bits of val into the chain, collecting what comes out of JTDO.
  task automatic shift_frame(input int val, input int n, output int rb);
    rb = 0;
    for (int i = 0; i < n; i++) begin
      tick(0, 1, 1, 0, val[i]);
      rb = rb | (int'(JTDO) << i);
    end
  endtask

  task automatic test_reset();
    int rb;
    tick(1, 1, 1, 1, 1);
    tick(1, 1, 0, 1, 0);
    n_vec++; if (REG_OUT !== '0) begin n_err++; $display("FAIL reset_reg_out: got %h expected 0", REG_OUT); end
    n_vec++; if (REG_WSTB !== '0) begin n_err++; $display("FAIL reset_wstb: got %b expected 0", REG_WSTB); end
    n_vec++; if (JTDO !== 1'b0) begin n_err++; $display("FAIL reset_jtdo: got %b expected 0", JTDO); end
    tick(0, 1, 0, 0, 0);
    for (int i = 0; i < FW; i++) begin
      tick(0, 1, 1, 0, 0);
      n_vec++; if (JTDO !== 1'b0) begin n_err++; $display("FAIL reset_shiftout bit %0d: got %b expected 0", i, JTDO); end
    end
  endtask

  task automatic test_write();
    int rb;
    shift_frame(32'h1A55, FW, rb);  // WR=1 ADDR=2 DATA=0x1A5
    tick(0, 0, 0, 1, 0);
    n_vec++; if (REG_OUT[26:18] !== 9'h1A5) begin n_err++; $display("FAIL write_data: got %h expected 1a5", REG_OUT[26:18]); end
    n_vec++; if (REG_WSTB !== 4'b0100) begin n_err++; $display("FAIL write_wstb: got %b expected 0100", REG_WSTB); end
    n_vec++; if ({REG_OUT[35:27], REG_OUT[17:0]} !== '0) begin n_err++; $display("FAIL write_others: got %h expected 0", REG_OUT); end
    tick(0, 0, 0, 0, 0);
    n_vec++; if (REG_WSTB !== 4'b0000) begin n_err++; $display("FAIL write_wstb_drop: got %b expected 0000", REG_WSTB); end
  endtask

  task automatic test_readback();
    int rb;
    tick(0, 1, 0, 0, 0);
    shift_frame(0, FW, rb);
    n_vec++; if (rb !== 32'h1A54) begin n_err++; $display("FAIL readback_frame: got %h expected 1a54", rb); end
    n_vec++; if (REG_OUT[26:18] !== 9'h1A5) begin n_err++; $display("FAIL readback_reg_keep: got %h expected 1a5", REG_OUT[26:18]); end
  endtask

  task automatic test_status();
    int rb;
    STATUS_IN = {9'h15A, 9'h0F3};
    shift_frame(32'h0008, FW, rb);  // WR=0 ADDR=4
    tick(0, 0, 0, 1, 0);
    n_vec++; if (REG_WSTB !== 4'b0000) begin n_err++; $display("FAIL status_wstb: got %b expected 0000", REG_WSTB); end
    tick(0, 1, 0, 0, 0);
    shift_frame(0, FW, rb);
    n_vec++; if (rb !== 32'h0F38) begin n_err++; $display("FAIL status_frame: got %h expected f38", rb); end
  endtask

  task automatic test_illegal();
    int rb;
    logic [NRW*DW-1:0] snap;
    snap = REG_OUT;
    shift_frame(32'h1FFB, FW, rb);  // WR=1 ADDR=5 DATA=0x1FF
    tick(0, 0, 0, 1, 0);
    n_vec++; if (REG_WSTB !== 4'b0000) begin n_err++; $display("FAIL illegal_wstb: got %b expected 0000", REG_WSTB); end
    n_vec++; if (REG_OUT !== snap) begin n_err++; $display("FAIL illegal_reg_out: got %h expected %h", REG_OUT, snap); end
    tick(0, 1, 0, 0, 0);
    shift_frame(32'h000E, FW, rb);  // readback, and load WR=0 ADDR=7
    n_vec++; if (rb !== 32'h15AB) begin n_err++; $display("FAIL illegal_err_frame: got %h expected 15ab", rb); end
    tick(0, 0, 0, 1, 0);
    tick(0, 1, 0, 0, 0);
    shift_frame(0, FW, rb);
    n_vec++; if (rb !== 32'h000E) begin n_err++; $display("FAIL unmapped_frame: got %h expected 000e", rb); end
  endtask

  task automatic test_gating();
    int rb;
    logic j0;
    logic [NRW*DW-1:0] snap;
    shift_frame(32'h0AA1, FW, rb);  // WR=1 ADDR=0 DATA=0x0AA
    j0 = JTDO;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1, 0, 1'($urandom_range(1)));
      n_vec++; if (JTDO !== j0) begin n_err++; $display("FAIL gate_jtdo_hold: got %b expected %b", JTDO, j0); end
    end
    tick(0, 0, 0, 1, 0);
    n_vec++; if (REG_OUT[8:0] !== 9'h0AA) begin n_err++; $display("FAIL gate_sr_hold: got %h expected 0aa", REG_OUT[8:0]); end
    n_vec++; if (REG_WSTB !== 4'b0001) begin n_err++; $display("FAIL gate_wstb: got %b expected 0001", REG_WSTB); end
    snap = REG_OUT;
    tick(0, 0, 0, 1, 0);  // second update without a shift
    n_vec++; if (REG_WSTB !== 4'b0000) begin n_err++; $display("FAIL noshift_update_wstb: got %b expected 0000", REG_WSTB); end
    n_vec++; if (REG_OUT !== snap) begin n_err++; $display("FAIL noshift_update_reg: got %h expected %h", REG_OUT, snap); end
    shift_frame(32'h1FF7, 6, rb);  // partial WR=1 ADDR=3 frame
    tick(1, 1, 1, 0, 1);
    tick(0, 0, 0, 1, 0);
    n_vec++; if (REG_OUT !== '0) begin n_err++; $display("FAIL midrst_reg_out: got %h expected 0", REG_OUT); end
    n_vec++; if (REG_WSTB !== '0) begin n_err++; $display("FAIL midrst_wstb: got %b expected 0", REG_WSTB); end
    n_vec++; if (JTDO !== 1'b0) begin n_err++; $display("FAIL midrst_jtdo: got %b expected 0", JTDO); end
  endtask

  task automatic test_random();
    bit rst, ce, sh, up, tdi;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) STATUS_IN = NRO*DW'($urandom);
      rst = ($urandom_range(127) == 0);
      ce  = ($urandom_range(9) < 8);
      sh  = ($urandom_range(9) < 7);
      up  = ($urandom_range(9) < 2);
      tdi = 1'($urandom_range(1));
      tick(rst, ce, sh, up, tdi);
      n_vec++; if (JTDO !== m_tdo[0]) begin n_err++; $display("FAIL rand_jtdo cyc %0d: got %b expected %b", c, JTDO, m_tdo[0]); end
      n_vec++; if (REG_OUT !== exp_reg()) begin n_err++; $display("FAIL rand_reg_out cyc %0d: got %h expected %h", c, REG_OUT, exp_reg()); end
      n_vec++; if (REG_WSTB !== m_wstb[NRW-1:0]) begin n_err++; $display("FAIL rand_wstb cyc %0d: got %b expected %b", c, REG_WSTB, m_wstb[NRW-1:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_status();
    test_illegal();
    test_gating();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_chain_regfile.md
Name: jtag_chain_regfile

Overview:
Parametrised JTAG user-chain data register that replaces the single fixed-width user chain with an addressed register file. A frame shifted through the chain carries a write flag, an address and a data word. On update, the frame either writes one of NUM_RW control registers or selects a register for readback. Capture loads the selected register, which is either a control register or one of NUM_RO read-only status words, plus an error flag. The block sits behind the JTAG primitive's user-chain strobes and drives LEDs and other control fabric.

Parameters:
DATA_W, 9, width of each register and of the frame data field
ADDR_W, 3, width of the frame address field
NUM_RW, 4, writable control registers, at addresses 0..NUM_RW-1
NUM_RO, 2, read-only status words, at addresses NUM_RW..NUM_RW+NUM_RO-1; NUM_RW+NUM_RO <= 2**ADDR_W is required (elaboration error otherwise)

Ports:
JTCK  input  1  JTAG test clock, the sole clock; all logic on its rising edge
JRST  input  1  synchronous active-high reset
JTDI  input  1  serial data in
JSHIFT  input  1  shift-DR state
JUPDATE  input  1  update-DR state
JCE  input  1  this chain selected
JTDO  output  1  registered serial data out
STATUS_IN  input  NUM_RO*DATA_W  status words; word k occupies [k*DATA_W +: DATA_W] and maps to address NUM_RW+k
REG_OUT  output  NUM_RW*DATA_W  control registers; register i occupies [i*DATA_W +: DATA_W]
REG_WSTB  output  NUM_RW  one-cycle write strobe per control register

Behaviour:
- FRAME_W = 1+ADDR_W+DATA_W.
  - Shift register SR[FRAME_W-1:0]: SR[0]=WR, SR[ADDR_W:1]=ADDR, SR[FRAME_W-1:ADDR_W+1]=DATA.
  - Frames travel LSB first.
- Reset (JRST=1 at a JTCK edge) clears SR, all registers, REG_OUT, REG_WSTB, JTDO, rd_ptr, err and sel to 0.
  - Reset has priority over every other event.
  - A frame in progress is discarded.
- Shift (JCE=1, JSHIFT=1): JTDO <= SR[0]; SR <= {JTDI, SR[FRAME_W-1:1]}; sel <= 1.
- Capture (JCE=1, JSHIFT=0): SR <= {rd_data, rd_ptr, err}.
  - rd_data is the register at rd_ptr as sampled at this edge.
  - Addresses 0..NUM_RW-1 return the control register.
  - Addresses NUM_RW..NUM_RW+NUM_RO-1 return the STATUS_IN word.
  - Any other address returns 0.
- JCE=0: SR and JTDO hold.
- Update (JUPDATE=1 and sel=1): decodes the pre-edge SR, then sel <= 0.
  - rd_ptr <= ADDR, always.
  - WR=1 and ADDR<NUM_RW: that register <= DATA; REG_OUT shows the new value and REG_WSTB[ADDR]=1 in the cycle after the edge; err <= 0.
  - WR=1 and ADDR>=NUM_RW: no write, no strobe; err <= 1.
  - WR=0: no write; err <= 0.
- JUPDATE with sel=0 (no shift since the last update) is ignored entirely.
- REG_WSTB is high for exactly one cycle per accepted write; otherwise 0.
- Simultaneous JUPDATE and shift/capture at one edge:
  - Update decodes the pre-edge SR.
  - The shift/capture still updates SR.
  - sel ends at 1 if a shift occurred at that edge, else 0.
- A partial frame (fewer than FRAME_W shifts) is decoded as-is; no length check.
- No combinational path from any input to JTDO.

Test Plan:
1. Reset: hold JRST 2 cycles with all strobes toggling -> REG_OUT=0, REG_WSTB=0, JTDO=0; capture then 13 shifts -> JTDO all zeros.
2. Write (defaults, FRAME_W=13): shift WR=1, ADDR=2, DATA=0x1A5 LSB first with JCE=1, then pulse JUPDATE -> REG_OUT[26:18]=0x1A5 and REG_WSTB=4'b0100 for exactly one cycle; other registers stay 0.
3. Readback: after scenario 2, capture then shift 13 -> JTDO bits give err=0, ADDR=2, DATA=0x1A5; REG_OUT unchanged.
4. Status read: STATUS_IN[8:0]=0x0F3; shift WR=0, ADDR=4; update; capture; shift -> DATA=0x0F3, ADDR=4, err=0, no REG_WSTB.
5. Illegal access:
   - WR=1, ADDR=5, DATA=0x1FF -> no REG_OUT change, no strobe; next capture gives err=1, DATA=STATUS_IN[17:9].
   - Then WR=0, ADDR=7 -> err=0, DATA=0.
6. Gating and priority:
   - JUPDATE with no prior shift -> no effect.
   - Shifting with JCE=0 -> SR and JTDO hold.
   - JRST asserted mid-frame after 6 shifts -> all state cleared; a following JUPDATE writes nothing.
